// File: rtl/y86_fetch_sequencer.sv
// y86_fetch_sequencer
// Multi-cycle Y86-64 instruction fetch controller in front of a byte-wide ROM
// with one cycle of read latency. It accepts a PC and reads one byte per cycle.
// The instruction length comes from byte 0. The bytes are assembled into
// icode/ifun/rA/rB/valC (little-endian), together with valP and a status code.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   fetch_req         start a fetch at fetch_pc (sampled only while fetch_busy=0)
//   fetch_pc[63:0]    instruction address
//   fetch_busy        high from the cycle after acceptance until the result cycle
//   mem_rd_en         ROM read strobe
//   mem_addr[63:0]    ROM byte address
//   mem_rdata[7:0]    ROM byte, valid the cycle after mem_rd_en
//   inst_valid        one-cycle result pulse; the fields are held afterwards
//   icode, ifun       byte 0 opcode fields
//   rA, rB            byte 1 register fields (4'hF when there is no register byte)
//   valC[63:0]        constant field
//   valP[63:0]        fetch_pc + length
//   inst_stat[2:0]    1=AOK 2=HLT 3=ADR 4=INS
//
// Optional feature macro: FETCH_HALT_LOCK_EN
//   When it is defined, any result other than AOK puts the block into LOCKED.
//   LOCKED lasts until rst.
module y86_fetch_sequencer #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [63:0] fetch_pc,
  output logic        fetch_busy,
  output logic        mem_rd_en,
  output logic [63:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        inst_valid,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [2:0]  inst_stat
);

  localparam logic [2:0]  STAT_AOK  = 3'd1;
  localparam logic [2:0]  STAT_HLT  = 3'd2;
  localparam logic [2:0]  STAT_ADR  = 3'd3;
  localparam logic [2:0]  STAT_INS  = 3'd4;
  localparam logic [64:0] MEM_LIMIT = 65'(MEM_BYTES);

`ifdef FETCH_HALT_LOCK_EN
  typedef enum logic [1:0] {IDLE, ISSUE, COLLECT, LOCKED} state_t;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, COLLECT} state_t;
`endif

  state_t      state, state_next;
  logic [63:0] pc_lat;
  logic [3:0]  k_cnt, k_next;
  logic [3:0]  icode_acc, ifun_acc, ra_acc, rb_acc;
  logic [63:0] valc_acc;

  logic [3:0]  icode_c, ifun_c, ra_c, rb_c, len_c, fin_len;
  logic [63:0] valc_c;
  logic [3:0]  issue_k;
  logic [64:0] addr_sum;
  logic        addr_ok, fin;
  logic [2:0]  fin_stat;

  function automatic logic [3:0] inst_len(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: inst_len = 4'd2;
      4'h3, 4'h4, 4'h5:       inst_len = 4'd10;
      4'h7, 4'h8:             inst_len = 4'd9;
      default:                inst_len = 4'd1;
    endcase
  endfunction

  function automatic logic has_reg(input logic [3:0] ic);
    has_reg = (ic == 4'h2) || (ic == 4'h3) || (ic == 4'h4) || (ic == 4'h5) ||
              (ic == 4'h6) || (ic == 4'hA) || (ic == 4'hB);
  endfunction

  function automatic logic ifun_ok(input logic [3:0] ic, input logic [3:0] fn);
    case (ic)
      4'h6:       ifun_ok = (fn <= 4'd3);
      4'h2, 4'h7: ifun_ok = (fn <= 4'd6);
      default:    ifun_ok = (fn == 4'd0);
    endcase
  endfunction

  // The next byte index is k in ISSUE and k+1 in COLLECT. The 65-bit sum
  // catches a 64-bit wrap as well as running past the end of the ROM.
  assign issue_k  = (state == COLLECT) ? k_cnt + 4'd1 : k_cnt;
  assign addr_sum = {1'b0, pc_lat} + {61'd0, issue_k};
  assign addr_ok  = addr_sum < MEM_LIMIT;

  assign fetch_busy = (state != IDLE);

  always_comb begin
    state_next = state;
    k_next     = k_cnt;
    mem_rd_en  = 1'b0;
    mem_addr   = 64'd0;
    fin        = 1'b0;
    fin_stat   = STAT_AOK;
    fin_len    = 4'd1;
    icode_c    = (k_cnt == 4'd0) ? mem_rdata[7:4] : icode_acc;
    ifun_c     = (k_cnt == 4'd0) ? mem_rdata[3:0] : ifun_acc;
    ra_c       = ra_acc;
    rb_c       = rb_acc;
    valc_c     = valc_acc;
    len_c      = inst_len(icode_c);

    // Place the incoming byte in its field. valC starts at byte 2 when there
    // is a register byte (icodes 3/4/5) and at byte 1 for jXX/call.
    if (state == COLLECT) begin
      if (k_cnt == 4'd1 && has_reg(icode_c)) begin
        ra_c = mem_rdata[7:4];
        rb_c = mem_rdata[3:0];
      end
      if ((icode_c == 4'h3 || icode_c == 4'h4 || icode_c == 4'h5) && k_cnt >= 4'd2)
        valc_c = valc_acc | ({56'd0, mem_rdata} << {k_cnt[2:0] - 3'd2, 3'b000});
      else if ((icode_c == 4'h7 || icode_c == 4'h8) && k_cnt >= 4'd1)
        valc_c = valc_acc | ({56'd0, mem_rdata} << {k_cnt[2:0] - 3'd1, 3'b000});
    end

    case (state)
      IDLE: begin
        if (fetch_req) state_next = ISSUE;
      end
      ISSUE: begin
        if (addr_ok) begin
          mem_rd_en  = 1'b1;
          mem_addr   = addr_sum[63:0];
          state_next = COLLECT;
        end else begin
          fin      = 1'b1;
          fin_stat = STAT_ADR;
        end
      end
      COLLECT: begin
        fin_len = len_c;
        if (k_cnt == 4'd0 && icode_c > 4'hB) begin
          fin      = 1'b1;
          fin_stat = STAT_INS;
          fin_len  = 4'd1;
        end else if (k_cnt == 4'd0 && !ifun_ok(icode_c, ifun_c)) begin
          fin      = 1'b1;
          fin_stat = STAT_INS;
        end else if (k_cnt + 4'd1 < len_c) begin
          if (addr_ok) begin
            mem_rd_en = 1'b1;
            mem_addr  = addr_sum[63:0];
            k_next    = k_cnt + 4'd1;
          end else begin
            fin      = 1'b1;
            fin_stat = STAT_ADR;
          end
        end else begin
          fin      = 1'b1;
          fin_stat = (icode_c == 4'h0) ? STAT_HLT : STAT_AOK;
        end
      end
      default: ;
    endcase

    if (fin) begin
`ifdef FETCH_HALT_LOCK_EN
      state_next = (fin_stat == STAT_AOK) ? IDLE : LOCKED;
`else
      state_next = IDLE;
`endif
    end
  end

  // Control state and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      inst_valid <= 1'b0;
      icode      <= 4'd0;
      ifun       <= 4'd0;
      rA         <= 4'd0;
      rB         <= 4'd0;
      valC       <= 64'd0;
      valP       <= 64'd0;
      inst_stat  <= STAT_AOK;
    end else begin
      state      <= state_next;
      inst_valid <= fin;
      if (fin) begin
        icode     <= (state == COLLECT) ? icode_c : 4'd0;
        ifun      <= (state == COLLECT) ? ifun_c : 4'd0;
        rA        <= ra_c;
        rB        <= rb_c;
        valC      <= valc_c;
        valP      <= pc_lat + {60'd0, fin_len};
        inst_stat <= fin_stat;
      end
    end
  end

  // Assembly registers. They are cleared when a fetch is accepted, so any
  // field that is never fetched reads as 0 (rA/rB read as F).
  always_ff @(posedge clk) begin
    if (state == IDLE && fetch_req) begin
      pc_lat    <= fetch_pc;
      k_cnt     <= 4'd0;
      icode_acc <= 4'd0;
      ifun_acc  <= 4'd0;
      ra_acc    <= 4'hF;
      rb_acc    <= 4'hF;
      valc_acc  <= 64'd0;
    end else if (state == COLLECT) begin
      k_cnt     <= k_next;
      icode_acc <= icode_c;
      ifun_acc  <= ifun_c;
      ra_acc    <= ra_c;
      rb_acc    <= rb_c;
      valc_acc  <= valc_c;
    end
  end

endmodule

// File: tb/tb_y86_fetch_sequencer.sv
module tb_y86_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [63:0] fetch_pc;
  logic        fetch_busy, mem_rd_en, inst_valid;
  logic [63:0] mem_addr, valC, valP;
  logic [7:0]  mem_rdata;
  logic [3:0]  icode, ifun, rA, rB;
  logic [2:0]  inst_stat;

  logic [7:0]  rom [0:1023];
  int          rd_count = 0;
  int          bad_addr = 0;
  int          idle_rd = 0;
  int          rd_start;
  int          checks = 0;
  int          passes = 0;

  always #5 clk = ~clk;

  y86_fetch_sequencer #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .fetch_busy(fetch_busy), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .inst_valid(inst_valid), .icode(icode), .ifun(ifun),
    .rA(rA), .rB(rB), .valC(valC), .valP(valP), .inst_stat(inst_stat)
  );

  // ROM model with one cycle of read latency, plus a bus monitor
  always @(posedge clk) begin
    if (mem_rd_en) begin
      rd_count = rd_count + 1;
      if (mem_addr >= 64'd1024) bad_addr = bad_addr + 1;
      else mem_rdata <= rom[mem_addr[9:0]];
      if (!fetch_busy) idle_rd = idle_rd + 1;
    end
  end

  task automatic do_reset();
    rst = 1'b1; fetch_req = 1'b0; fetch_pc = 64'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns at the negedge of cycle N+1, where cycle N is the accept cycle
  task automatic start_fetch(input logic [63:0] pc);
    @(negedge clk);
    fetch_pc = pc; fetch_req = 1'b1; rd_start = rd_count;
    @(negedge clk);
    fetch_req = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (inst_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_req = 1'b0; fetch_pc = 64'd0;
    repeat (2) @(negedge clk);
    checks++; if ({fetch_busy, mem_rd_en, inst_valid} !== 3'b000) $display("FAIL reset_ctrl got %b want 000", {fetch_busy, mem_rd_en, inst_valid}); else passes++;
    checks++; if (mem_addr !== 64'd0) $display("FAIL reset_addr got %h want 0", mem_addr); else passes++;
    checks++; if ({icode, ifun, rA, rB} !== 16'h0000) $display("FAIL reset_fields got %h want 0000", {icode, ifun, rA, rB}); else passes++;
    checks++; if (valC !== 64'd0 || valP !== 64'd0) $display("FAIL reset_vals got %h/%h want 0/0", valC, valP); else passes++;
    checks++; if (inst_stat !== 3'd1) $display("FAIL reset_stat got %0d want 1", inst_stat); else passes++;
    rst = 1'b0;
  endtask

  task automatic test_irmovq();
    int lat;
    logic [7:0] b [0:9];
    b = '{8'h30, 8'hF3, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    for (int i = 0; i < 10; i++) rom[i] = b[i];
    start_fetch(64'd0);
    wait_valid(lat);
    checks++; if (lat != 12) $display("FAIL irmovq_latency got %0d want 12", lat); else passes++;
    checks++; if ({icode, ifun, rA, rB} !== 16'h30F3) $display("FAIL irmovq_fields got %h want 30f3", {icode, ifun, rA, rB}); else passes++;
    checks++; if (valC !== 64'h0102030405060708) $display("FAIL irmovq_valC got %h want 0102030405060708", valC); else passes++;
    checks++; if (valP !== 64'd10 || inst_stat !== 3'd1) $display("FAIL irmovq_valP_stat got %0d/%0d want 10/1", valP, inst_stat); else passes++;
    checks++; if (rd_count - rd_start != 10) $display("FAIL irmovq_reads got %0d want 10", rd_count - rd_start); else passes++;
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0 || valC !== 64'h0102030405060708) $display("FAIL irmovq_hold got %b/%h want 0/held", inst_valid, valC); else passes++;
  endtask

  task automatic test_halt();
    int lat;
    rom[5] = 8'h00;
    start_fetch(64'd5);
    wait_valid(lat);
    checks++; if (lat != 3) $display("FAIL halt_latency got %0d want 3", lat); else passes++;
    checks++; if (icode !== 4'h0 || rA !== 4'hF || valP !== 64'd6) $display("FAIL halt_fields got %h/%h/%0d want 0/f/6", icode, rA, valP); else passes++;
    checks++; if (inst_stat !== 3'd2) $display("FAIL halt_stat got %0d want 2", inst_stat); else passes++;
    checks++; if (rd_count - rd_start != 1) $display("FAIL halt_reads got %0d want 1", rd_count - rd_start); else passes++;
  endtask

  task automatic test_bad_icode_then_req();
    int lat;
    do_reset();
    rom[0] = 8'hF0;
    start_fetch(64'd0);
    wait_valid(lat);
    checks++; if (lat != 3) $display("FAIL ins_latency got %0d want 3", lat); else passes++;
    checks++; if (inst_stat !== 3'd4 || valP !== 64'd1) $display("FAIL ins_stat_valP got %0d/%0d want 4/1", inst_stat, valP); else passes++;
    checks++; if ({icode, rA, rB} !== 12'hFFF || valC !== 64'd0) $display("FAIL ins_fields got %h/%h want fff/0", {icode, rA, rB}, valC); else passes++;
    rom[0] = 8'h10;
    start_fetch(64'd0);
`ifdef FETCH_HALT_LOCK_EN
    lat = 0;
    repeat (5) begin
      if (inst_valid === 1'b1 || fetch_busy !== 1'b1) lat++;
      @(negedge clk);
    end
    checks++; if (lat != 0) $display("FAIL locked_ignore got %0d bad cycles want 0", lat); else passes++;
    checks++; if (inst_stat !== 3'd4) $display("FAIL locked_hold got %0d want 4", inst_stat); else passes++;
    do_reset();
`else
    wait_valid(lat);
    checks++; if (lat != 3) $display("FAIL after_ins_latency got %0d want 3", lat); else passes++;
    checks++; if (inst_stat !== 3'd1 || valP !== 64'd1) $display("FAIL after_ins_stat got %0d/%0d want 1/1", inst_stat, valP); else passes++;
`endif
  endtask

  task automatic test_bad_ifun();
    int lat;
    rom[0] = 8'h65;
    start_fetch(64'd0);
    wait_valid(lat);
    checks++; if (lat != 3) $display("FAIL badifun_latency got %0d want 3", lat); else passes++;
    checks++; if (inst_stat !== 3'd4 || valP !== 64'd2 || rA !== 4'hF) $display("FAIL badifun got %0d/%0d/%h want 4/2/f", inst_stat, valP, rA); else passes++;
  endtask

  task automatic test_adr_end();
    int lat;
    int bad0;
    do_reset();
    rom[1020] = 8'h80; rom[1021] = 8'h11; rom[1022] = 8'h22; rom[1023] = 8'h33;
    bad0 = bad_addr;
    start_fetch(64'd1020);
    wait_valid(lat);
    checks++; if (lat != 6) $display("FAIL adr_latency got %0d want 6", lat); else passes++;
    checks++; if (inst_stat !== 3'd3 || valP !== 64'd1029) $display("FAIL adr_stat_valP got %0d/%0d want 3/1029", inst_stat, valP); else passes++;
    checks++; if (icode !== 4'h8 || rA !== 4'hF) $display("FAIL adr_fields got %h/%h want 8/f", icode, rA); else passes++;
    checks++; if (rd_count - rd_start != 4) $display("FAIL adr_reads got %0d want 4", rd_count - rd_start); else passes++;
    checks++; if (bad_addr != bad0) $display("FAIL adr_range got %0d want 0", bad_addr - bad0); else passes++;
  endtask

  task automatic test_adr_wrap();
    int lat;
    do_reset();
    start_fetch(64'hFFFF_FFFF_FFFF_FFFF);
    wait_valid(lat);
    checks++; if (lat != 2) $display("FAIL wrap_latency got %0d want 2", lat); else passes++;
    checks++; if (inst_stat !== 3'd3 || valP !== 64'd0) $display("FAIL wrap_stat_valP got %0d/%h want 3/0", inst_stat, valP); else passes++;
    checks++; if (rd_count - rd_start != 0) $display("FAIL wrap_reads got %0d want 0", rd_count - rd_start); else passes++;
    do_reset();
  endtask

  task automatic test_rst_mid_fetch();
    int lat;
    int stray;
    logic [7:0] b [0:9];
    b = '{8'h30, 8'hF3, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    for (int i = 0; i < 10; i++) rom[i] = b[i];
    rom[20] = 8'h00;
    start_fetch(64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({fetch_busy, mem_rd_en, inst_valid} !== 3'b000) $display("FAIL rst_abort got %b want 000", {fetch_busy, mem_rd_en, inst_valid}); else passes++;
    rst = 1'b0;
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (inst_valid === 1'b1) stray++;
    end
    checks++; if (stray != 0) $display("FAIL rst_no_valid got %0d want 0", stray); else passes++;
    start_fetch(64'd20);
    wait_valid(lat);
    checks++; if (lat != 3 || inst_stat !== 3'd2 || valP !== 64'd21) $display("FAIL rst_refetch got %0d/%0d/%0d want 3/2/21", lat, inst_stat, valP); else passes++;
  endtask

  task automatic test_back_to_back();
    int c;
    int n;
    int cyc [0:1];
    logic [63:0] vp [0:1];
    rom[0] = 8'h10; rom[1] = 8'h90;
    cyc = '{0, 0}; vp = '{64'd0, 64'd0};
    @(negedge clk);
    fetch_pc = 64'd0; fetch_req = 1'b1;
    @(negedge clk);
    fetch_pc = 64'd1;
    c = 1; n = 0;
    while (n < 2 && c < 30) begin
      if (inst_valid === 1'b1) begin
        cyc[n] = c; vp[n] = valP; n++;
        if (n == 2) fetch_req = 1'b0;
      end
      if (n < 2) begin
        @(negedge clk);
        c++;
      end
    end
    fetch_req = 1'b0;
    checks++; if (n != 2) $display("FAIL b2b_count got %0d want 2", n); else passes++;
    checks++; if (cyc[0] != 3 || cyc[1] - cyc[0] != 3) $display("FAIL b2b_timing got %0d/%0d want 3/6", cyc[0], cyc[1]); else passes++;
    checks++; if (vp[0] !== 64'd1 || vp[1] !== 64'd2) $display("FAIL b2b_valP got %0d/%0d want 1/2", vp[0], vp[1]); else passes++;
    repeat (3) @(negedge clk);
    checks++; if (idle_rd != 0) $display("FAIL idle_read got %0d want 0", idle_rd); else passes++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
    mem_rdata = 8'h00;
    test_reset();
    test_irmovq();
    test_halt();
    test_bad_icode_then_req();
    test_bad_ifun();
    test_adr_end();
    test_adr_wrap();
    test_rst_mid_fetch();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
